imm_gen_pipe: RTL and testbench

Parametrised immediate generator for the decode stage. Adds U, CSR-zimm and shift-amount formats, XLEN of 32 or 64, and an optional opcode-driven format decoder. The output pipeline depth is configurable from 0 to 2 stages, with pipeline stall and flush control. It feeds ImmExtE to the execute-stage ALU-B mux and to the branch/jump target adder.

---
 rtl/imm_pkg.sv | 26 ++
 rtl/imm_decode.sv | 58 +++++
 rtl/imm_gen_pipe.sv | 99 +++++++++
 tb/tb_imm_gen_pipe.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared constants for the immediate generator: format codes and the
// RISC-V major opcodes recognised by the opcode-driven format decoder.
package imm_pkg;

    // Immediate format codes (ImmSrc / ImmFmt encoding)
    localparam logic [2:0] IMM_I   = 3'b000;
    localparam logic [2:0] IMM_S   = 3'b001;
    localparam logic [2:0] IMM_B   = 3'b010;
    localparam logic [2:0] IMM_J   = 3'b011;
    localparam logic [2:0] IMM_U   = 3'b100;
    localparam logic [2:0] IMM_Z   = 3'b101;
    localparam logic [2:0] IMM_SH  = 3'b110;
    localparam logic [2:0] IMM_RSV = 3'b111;

    // Major opcodes, instr[6:0]
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: picks the format (from src, or from the
// opcode when auto is set) and builds the XLEN-wide extended immediate.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      src,
    input  logic            auto,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [2:0] auto_fmt;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    // Derive the format from opcode/funct3; unknown opcodes map to reserved
    always_comb begin
        auto_fmt = IMM_RSV;
        case (opcode)
            OP_LOAD, OP_JALR: auto_fmt = IMM_I;
            OP_IMM:           auto_fmt = (funct3 == 3'b001 || funct3 == 3'b101) ? IMM_SH : IMM_I;
            OP_STORE:         auto_fmt = IMM_S;
            OP_BRANCH:        auto_fmt = IMM_B;
            OP_JAL:           auto_fmt = IMM_J;
            OP_LUI, OP_AUIPC: auto_fmt = IMM_U;
            OP_SYSTEM:        auto_fmt = funct3[2] ? IMM_Z : IMM_I;
            default:          auto_fmt = IMM_RSV;
        endcase
    end

    assign fmt = auto ? auto_fmt : src;

    // Assemble the immediate for the selected format; sized casts of signed
    // values sign-extend to XLEN, unsigned ones zero-extend
    always_comb begin
        // NOTE: defaults first so every path assigns imm and illegal; no latch is inferred.
        imm     = '0;
        illegal = 1'b0;
        case (fmt)
            IMM_I:  imm = XLEN'($signed(instr[31:20]));
            IMM_S:  imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            IMM_B:  imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            IMM_J:  imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            IMM_U:  imm = XLEN'($signed({instr[31:12], 12'b0}));
            IMM_Z:  imm = XLEN'(instr[19:15]);
            IMM_SH: imm = (XLEN == 32) ? XLEN'(instr[24:20]) : XLEN'(instr[25:20]);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator with a 0..2 stage output pipeline.
// Flush beats stall; an empty slot always carries all-zero payload.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int PIPE_STAGES = 1,
    parameter int AUTO_DECODE = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     InstrD,
    input  logic [2:0]      ImmSrcD,
    input  logic            ValidD,
    input  logic            StallE,
    input  logic            FlushE,
    output logic [XLEN-1:0] ImmExtE,
    output logic [2:0]      ImmFmtE,
    output logic            ImmValidE,
    output logic            IllegalImmE
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } stage_t;

    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_illegal;
    stage_t          stage_in;
    stage_t          out_s;

    imm_decode #(
        .XLEN(XLEN)
    ) u_decode (
        .instr  (InstrD),
        .src    (ImmSrcD),
        .auto   (AUTO_DECODE != 0),
        .imm    (dec_imm),
        .fmt    (dec_fmt),
        .illegal(dec_illegal)
    );

    // Gate the decoded fields with ValidD so an empty slot carries zeros
    always_comb begin
        stage_in = '0;
        if (ValidD) begin
            stage_in.valid   = 1'b1;
            stage_in.imm     = dec_imm;
            stage_in.fmt     = dec_fmt;
            stage_in.illegal = dec_illegal;
        end
    end

    generate
        if (PIPE_STAGES == 0) begin : g_comb
            // Pass-through: flush squashes the slot, stall has no effect
            always_comb begin
                out_s = FlushE ? '0 : stage_in;
            end
        end else begin : g_pipe
            stage_t pipe_q [PIPE_STAGES];

            for (genvar g = 0; g < PIPE_STAGES; g++) begin : g_stage
                stage_t d;

                if (g == 0) begin : g_first
                    assign d = stage_in;
                end else begin : g_next
                    assign d = pipe_q[g-1];
                end

                // Stage register: flush clears, stall holds, otherwise advance
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        // NOTE: reset clears valid and payload, so downstream sees zeros immediately.
                        pipe_q[g] <= '0;
                    end else if (FlushE) begin
                        // NOTE: state updates use non-blocking assignment so all stages shift in step.
                        pipe_q[g] <= '0;
                    end else if (!StallE) begin
                        pipe_q[g] <= d;
                    end
                end
            end

            assign out_s = pipe_q[PIPE_STAGES-1];
        end
    endgenerate

    assign ImmExtE     = out_s.imm;
    assign ImmFmtE     = out_s.fmt;
    assign ImmValidE   = out_s.valid;
    assign IllegalImmE = out_s.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench: four configurations share one input bus.
//   u_a: XLEN=32 P=1 manual   u_b: XLEN=64 P=2 manual
//   u_c: XLEN=32 P=1 auto     u_d: XLEN=32 P=0 manual
module tb_imm_gen_pipe;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic [2:0]  src;
    logic        valid;
    logic        stall;
    logic        flush;

    logic [31:0] a_imm;  logic [2:0] a_fmt;  logic a_valid;  logic a_ill;
    logic [63:0] b_imm;  logic [2:0] b_fmt;  logic b_valid;  logic b_ill;
    logic [31:0] c_imm;  logic [2:0] c_fmt;  logic c_valid;  logic c_ill;
    logic [31:0] d_imm;  logic [2:0] d_fmt;  logic d_valid;  logic d_ill;

    int checks = 0;
    int errors = 0;

    imm_gen_pipe #(.XLEN(32), .PIPE_STAGES(1), .AUTO_DECODE(0)) u_a (
        .clk(clk), .rst_n(rst_n), .InstrD(instr), .ImmSrcD(src), .ValidD(valid),
        .StallE(stall), .FlushE(flush),
        .ImmExtE(a_imm), .ImmFmtE(a_fmt), .ImmValidE(a_valid), .IllegalImmE(a_ill));

    imm_gen_pipe #(.XLEN(64), .PIPE_STAGES(2), .AUTO_DECODE(0)) u_b (
        .clk(clk), .rst_n(rst_n), .InstrD(instr), .ImmSrcD(src), .ValidD(valid),
        .StallE(stall), .FlushE(flush),
        .ImmExtE(b_imm), .ImmFmtE(b_fmt), .ImmValidE(b_valid), .IllegalImmE(b_ill));

    imm_gen_pipe #(.XLEN(32), .PIPE_STAGES(1), .AUTO_DECODE(1)) u_c (
        .clk(clk), .rst_n(rst_n), .InstrD(instr), .ImmSrcD(src), .ValidD(valid),
        .StallE(stall), .FlushE(flush),
        .ImmExtE(c_imm), .ImmFmtE(c_fmt), .ImmValidE(c_valid), .IllegalImmE(c_ill));

    imm_gen_pipe #(.XLEN(32), .PIPE_STAGES(0), .AUTO_DECODE(0)) u_d (
        .clk(clk), .rst_n(rst_n), .InstrD(instr), .ImmSrcD(src), .ValidD(valid),
        .StallE(stall), .FlushE(flush),
        .ImmExtE(d_imm), .ImmFmtE(d_fmt), .ImmValidE(d_valid), .IllegalImmE(d_ill));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  src;
        logic        valid;
        logic [31:0] exp32;
        logic [63:0] exp64;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  fmt;
        logic [31:0] exp32;
        logic        ill;
    } auto_vec_t;

    localparam int NV = 14;
    localparam int NA = 14;
    vec_t      vecs  [NV];
    auto_vec_t avecs [NA];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] addi(input logic [11:0] v);
        return {v, 20'h00093};
    endfunction

    initial begin
        // Manual-format vectors: {instr, src, valid, exp32, exp64, fmt, illegal}
        vecs[0]  = '{32'hFFF00093, 3'b000, 1'b1, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 3'b000, 1'b0};
        vecs[1]  = '{32'h0020A423, 3'b001, 1'b1, 32'h00000008, 64'h00000000_00000008, 3'b001, 1'b0};
        vecs[2]  = '{32'hFE000EE3, 3'b010, 1'b1, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 3'b010, 1'b0};
        vecs[3]  = '{32'h123452B7, 3'b100, 1'b1, 32'h12345000, 64'h00000000_12345000, 3'b100, 1'b0};
        vecs[4]  = '{32'h000FD073, 3'b101, 1'b1, 32'h0000001F, 64'h00000000_0000001F, 3'b101, 1'b0};
        vecs[5]  = '{32'hFFDFF06F, 3'b011, 1'b1, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 3'b011, 1'b0};
        vecs[6]  = '{32'h01F0D093, 3'b110, 1'b1, 32'h0000001F, 64'h00000000_0000001F, 3'b110, 1'b0};
        vecs[7]  = '{32'h03F0D093, 3'b110, 1'b1, 32'h0000001F, 64'h00000000_0000003F, 3'b110, 1'b0};
        vecs[8]  = '{32'h12345678, 3'b111, 1'b1, 32'h00000000, 64'h00000000_00000000, 3'b111, 1'b1};
        vecs[9]  = '{32'h7FF00093, 3'b000, 1'b1, 32'h000007FF, 64'h00000000_000007FF, 3'b000, 1'b0};
        vecs[10] = '{32'hFE000FA3, 3'b001, 1'b1, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 3'b001, 1'b0};
        vecs[11] = '{32'h800002B7, 3'b100, 1'b1, 32'h80000000, 64'hFFFFFFFF_80000000, 3'b100, 1'b0};
        vecs[12] = '{32'hFFF00093, 3'b000, 1'b0, 32'h00000000, 64'h00000000_00000000, 3'b000, 1'b0};
        vecs[13] = '{32'hFFFFFFFF, 3'b101, 1'b1, 32'h0000001F, 64'h00000000_0000001F, 3'b101, 1'b0};

        // Opcode-decoded vectors: {instr, fmt, exp32, illegal}
        avecs[0]  = '{32'h01F0D093, 3'b110, 32'h0000001F, 1'b0};
        avecs[1]  = '{32'h0000007F, 3'b111, 32'h00000000, 1'b1};
        avecs[2]  = '{32'hFFF00093, 3'b000, 32'hFFFFFFFF, 1'b0};
        avecs[3]  = '{32'h0020A423, 3'b001, 32'h00000008, 1'b0};
        avecs[4]  = '{32'hFE000EE3, 3'b010, 32'hFFFFFFFC, 1'b0};
        avecs[5]  = '{32'hFFDFF06F, 3'b011, 32'hFFFFFFFC, 1'b0};
        avecs[6]  = '{32'h123452B7, 3'b100, 32'h12345000, 1'b0};
        avecs[7]  = '{32'h12345297, 3'b100, 32'h12345000, 1'b0};
        avecs[8]  = '{32'h000FD073, 3'b101, 32'h0000001F, 1'b0};
        avecs[9]  = '{32'h30002073, 3'b000, 32'h00000300, 1'b0};
        avecs[10] = '{32'h00C12083, 3'b000, 32'h0000000C, 1'b0};
        avecs[11] = '{32'h00008067, 3'b000, 32'h00000000, 1'b0};
        avecs[12] = '{32'h00209093, 3'b110, 32'h00000002, 1'b0};
        avecs[13] = '{32'h4020D093, 3'b110, 32'h00000002, 1'b0};

        clk   = 1'b0;
        rst_n = 1'b0;
        instr = '0;
        src   = '0;
        valid = 1'b0;
        stall = 1'b0;
        flush = 1'b0;

        // Reset state
        #1;
        check("rst_a_imm",   64'(a_imm),   64'h0);
        check("rst_a_valid", 64'(a_valid), 64'h0);
        check("rst_b_imm",   b_imm,        64'h0);
        check("rst_b_fmt",   64'(b_fmt),   64'h0);
        check("rst_b_valid", 64'(b_valid), 64'h0);
        check("rst_c_ill",   64'(c_ill),   64'h0);
        #11 rst_n = 1'b1;

        // Manual formats, back to back: P=0 now, P=1 next cycle, P=2 one later
        for (int i = 0; i < NV; i++) begin
            instr = vecs[i].instr;
            src   = vecs[i].src;
            valid = vecs[i].valid;
            #1;
            check($sformatf("p0_imm[%0d]", i),   64'(d_imm),   64'(vecs[i].exp32));
            check($sformatf("p0_valid[%0d]", i), 64'(d_valid), 64'(vecs[i].valid));
            step();
            check($sformatf("p1_imm[%0d]", i),   64'(a_imm),   64'(vecs[i].exp32));
            check($sformatf("p1_fmt[%0d]", i),   64'(a_fmt),   64'(vecs[i].fmt));
            check($sformatf("p1_valid[%0d]", i), 64'(a_valid), 64'(vecs[i].valid));
            check($sformatf("p1_ill[%0d]", i),   64'(a_ill),   64'(vecs[i].ill));
            if (i > 0) begin
                check($sformatf("p2_imm[%0d]", i-1), b_imm,        vecs[i-1].exp64);
                check($sformatf("p2_fmt[%0d]", i-1), 64'(b_fmt),   64'(vecs[i-1].fmt));
                check($sformatf("p2_ill[%0d]", i-1), 64'(b_ill),   64'(vecs[i-1].ill));
            end
        end
        valid = 1'b0;
        step();
        check("p2_imm_last",   b_imm,        vecs[NV-1].exp64);
        check("p2_valid_last", 64'(b_valid), 64'h1);

        // Opcode-driven format selection; ImmSrcD set to reserved to show it is ignored
        src   = 3'b111;
        valid = 1'b1;
        for (int i = 0; i < NA; i++) begin
            instr = avecs[i].instr;
            step();
            check($sformatf("auto_imm[%0d]", i),   64'(c_imm),   64'(avecs[i].exp32));
            check($sformatf("auto_fmt[%0d]", i),   64'(c_fmt),   64'(avecs[i].fmt));
            check($sformatf("auto_ill[%0d]", i),   64'(c_ill),   64'(avecs[i].ill));
            check($sformatf("auto_valid[%0d]", i), 64'(c_valid), 64'h1);
        end

        // Stall mid-stream on the two-stage pipe: hold, then resume in order
        src   = 3'b000;
        valid = 1'b0;
        step();
        step();
        valid = 1'b1;
        instr = addi(12'd1);
        step();
        instr = addi(12'd2);
        step();
        check("stall_pre_b", b_imm, 64'd1);
        instr = addi(12'd3);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("stall_hold_b[%0d]", k),     b_imm,        64'd1);
            check($sformatf("stall_hold_bv[%0d]", k),    64'(b_valid), 64'h1);
            check($sformatf("stall_hold_a[%0d]", k),     64'(a_imm),   64'd2);
        end
        stall = 1'b0;
        step();
        check("stall_resume_2", b_imm, 64'd2);
        instr = addi(12'd4);
        step();
        check("stall_resume_3", b_imm, 64'd3);
        instr = addi(12'd5);
        step();
        check("stall_resume_4", b_imm, 64'd4);
        valid = 1'b0;
        step();
        check("stall_resume_5", b_imm, 64'd5);
        step();
        check("stall_drain_v",   64'(b_valid), 64'h0);
        check("stall_drain_imm", b_imm,        64'h0);

        // Flush together with stall squashes every stage
        valid = 1'b1;
        instr = addi(12'd7);
        step();
        instr = addi(12'd8);
        step();
        check("flush_pre_b", b_imm, 64'd7);
        instr = addi(12'd9);
        flush = 1'b1;
        stall = 1'b1;
        #1;
        check("flush_p0_valid", 64'(d_valid), 64'h0);
        step();
        check("flush_a_valid", 64'(a_valid), 64'h0);
        check("flush_a_imm",   64'(a_imm),   64'h0);
        check("flush_b_valid", 64'(b_valid), 64'h0);
        check("flush_b_imm",   b_imm,        64'h0);
        flush = 1'b0;
        stall = 1'b0;
        valid = 1'b0;
        step();
        check("flush_s1_b_valid", 64'(b_valid), 64'h0);
        check("flush_s1_b_imm",   b_imm,        64'h0);

        // Asynchronous reset between edges with the pipe full
        valid = 1'b1;
        instr = 32'hFFDFF06F;
        src   = 3'b011;
        step();
        step();
        check("arst_pre_b_imm", b_imm,      64'hFFFFFFFF_FFFFFFFC);
        check("arst_pre_b_fmt", 64'(b_fmt), 64'h3);
        #1 rst_n = 1'b0;
        #1;
        check("arst_b_imm",   b_imm,        64'h0);
        check("arst_b_fmt",   64'(b_fmt),   64'h0);
        check("arst_b_valid", 64'(b_valid), 64'h0);
        check("arst_a_imm",   64'(a_imm),   64'h0);
        check("arst_a_valid", 64'(a_valid), 64'h0);
        instr = addi(12'd12);
        src   = 3'b000;
        #1 rst_n = 1'b1;
        step();
        check("arst_rel_a_imm",   64'(a_imm),   64'd12);
        check("arst_rel_b_valid", 64'(b_valid), 64'h0);
        step();
        check("arst_rel_b_imm",   b_imm,        64'd12);
        check("arst_rel_b_valid2", 64'(b_valid), 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
